// File: rtl/aes_pkg.sv
// Shared AES widths and the scheduler state encoding used by the AES sharing blocks.
package aes_pkg;
   localparam int AES_BLK_W = 128;
   localparam int AES_KEY_W = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);
   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      idx       = 0;
      // Walk offsets from farthest to nearest so the nearest valid request wins.
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx = (int'(ptr) + off) % NREQ;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
         end
      end
   end
endmodule

// File: rtl/aes_core_sched.sv
// Round-robin scheduler sharing one combinational AES-128 core; operands are held for
// SETTLE_CYCLES so the core can be constrained as a multicycle path from core_* registers.
module aes_core_sched
   import aes_pkg::*;
#(
   parameter int NREQ          = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int IDW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*AES_BLK_W-1:0] req_plaintext,
   input  logic [NREQ*AES_KEY_W-1:0] req_cipher_key,
   output logic [AES_BLK_W-1:0]      core_plaintext,
   output logic [AES_KEY_W-1:0]      core_cipher_key,
   input  logic [AES_BLK_W-1:0]      core_ciphertext,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [AES_BLK_W-1:0]      rsp_ciphertext,
   output logic [IDW-1:0]            rsp_id,
   output logic                      busy
);
   localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNTW-1:0] CNT_INIT = CNTW'(SETTLE_CYCLES - 1);

   sched_state_e          state_reg;
   logic [IDW-1:0]        ptr_reg;
   logic [CNTW-1:0]       cnt_reg;
   logic [NREQ-1:0]       grant;
   logic [IDW-1:0]        grant_idx;
   logic [IDW-1:0]        ptr_next;
   logic                  accept;
   logic [AES_BLK_W-1:0]  pt_arr  [NREQ];
   logic [AES_KEY_W-1:0]  key_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign pt_arr[gi]  = req_plaintext[gi*AES_BLK_W +: AES_BLK_W];
      assign key_arr[gi] = req_cipher_key[gi*AES_KEY_W +: AES_KEY_W];
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Ready is offered only in IDLE, and is forced low while reset is held.
   assign req_ready = (state_reg == IDLE && rst_n) ? grant : '0;
   assign accept    = |(req_valid & req_ready);
   assign ptr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         ptr_reg         <= '0;
         cnt_reg         <= '0;
         core_plaintext  <= '0;
         core_cipher_key <= '0;
         rsp_valid       <= 1'b0;
         rsp_ciphertext  <= '0;
         rsp_id          <= '0;
         busy            <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  core_plaintext  <= pt_arr[grant_idx];
                  core_cipher_key <= key_arr[grant_idx];
                  rsp_id          <= grant_idx;
                  ptr_reg         <= ptr_next;
                  cnt_reg         <= CNT_INIT;
                  busy            <= 1'b1;
                  state_reg       <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end else begin
                  rsp_ciphertext <= core_ciphertext;
                  rsp_valid      <= 1'b1;
                  state_reg      <= HOLD;
               end
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule
